// File: rtl/debounce_edge_strobe.sv
// Debounces one raw asynchronous input into a registered level plus single-cycle
// rise/fall/change strobes aligned with the first cycle of the new level.
module debounce_edge_strobe #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH       = 10,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic sample_en,
    output logic q_level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic change_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE,
        SETTLE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 sync1;
    logic                 sync2;
    logic                 q_level_d;
    logic                 rise_d;
    logic                 fall_d;

    // Two-flop synchronizer; only sync2 is used beyond this point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= STABLE;
            cnt_q        <= '0;
            q_level      <= RESET_LEVEL;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            change_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            q_level      <= q_level_d;
            rise_pulse   <= rise_d;
            fall_pulse   <= fall_d;
            change_pulse <= rise_d | fall_d;
        end
    end

    // A return of sync2 to the current level aborts the settle regardless of sample_en.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_level_d = q_level;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync2 != q_level) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sync2 == q_level) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (!sample_en) begin
                    state_d = SETTLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE;
                    cnt_d     = '0;
                    q_level_d = sync2;
                    rise_d    = sync2;
                    fall_d    = ~sync2;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_edge_strobe.sv
// Directed bench for debounce_edge_strobe: DEBOUNCE_CYCLES=4 main instance plus a
// DEBOUNCE_CYCLES=1 instance for the minimum-parameter case.
module tb_debounce_edge_strobe;

    logic clk;
    logic rst;
    logic din;
    logic sample_en;
    logic q;
    logic rp;
    logic fp;
    logic cp;
    logic din1;
    logic q1;
    logic rp1;
    logic fp1;
    logic cp1;

    int total;
    int bad;

    debounce_edge_strobe #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .sample_en   (sample_en),
        .q_level     (q),
        .rise_pulse  (rp),
        .fall_pulse  (fp),
        .change_pulse(cp)
    );

    debounce_edge_strobe #(
        .DEBOUNCE_CYCLES(1),
        .CNT_WIDTH      (1),
        .RESET_LEVEL    (1'b0)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .din         (din1),
        .sample_en   (1'b1),
        .q_level     (q1),
        .rise_pulse  (rp1),
        .fall_pulse  (fp1),
        .change_pulse(cp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din1 = 1'b0; sample_en = 1'b1;
        repeat (3) tick();
        total++;
        if ({q, rp, fp, cp} !== 4'b0000) begin
            bad++; $display("FAIL reset_state: q/rp/fp/cp=%b expected 0000", {q, rp, fp, cp});
        end
        total++;
        if (dut.cnt_q !== 3'd0) begin
            bad++; $display("FAIL reset_cnt: cnt=%0d expected 0", dut.cnt_q);
        end
        // Release with din already high: one full debounce, rise after edge 7.
        din = 1'b1; rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if ({q, rp, fp, cp} !== {(e >= 7), (e == 7), 1'b0, (e == 7)}) begin
                bad++;
                $display("FAIL reset_release edge %0d: q/rp/fp/cp=%b expected %b", e,
                         {q, rp, fp, cp}, {(e >= 7), (e == 7), 1'b0, (e == 7)});
            end
        end
        // Mid-cycle asynchronous assertion clears outputs without a clock edge.
        #2; rst = 1'b1; #1;
        total++;
        if ({q, rp, fp, cp} !== 4'b0000) begin
            bad++; $display("FAIL reset_async: q/rp/fp/cp=%b expected 0000", {q, rp, fp, cp});
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if ({q, rp, fp, cp} !== {(e >= 7), (e == 7), 1'b0, (e == 7)}) begin
                bad++;
                $display("FAIL reset_rerelease edge %0d: q/rp/fp/cp=%b expected %b", e,
                         {q, rp, fp, cp}, {(e >= 7), (e == 7), 1'b0, (e == 7)});
            end
        end
    endtask

    task automatic test_clean_step();
        logic [2:0] seq;
        seq = 3'b010;
        for (int s = 0; s < 3; s++) begin
            logic nv;
            nv  = seq[s];
            din = nv;
            for (int e = 1; e <= 9; e++) begin
                logic eq;
                logic er;
                logic ef;
                tick();
                eq = (e >= 7) ? nv : ~nv;
                er = (e == 7) && nv;
                ef = (e == 7) && !nv;
                total++;
                if ({q, rp, fp, cp} !== {eq, er, ef, er | ef}) begin
                    bad++;
                    $display("FAIL clean_step to %b edge %0d: q/rp/fp/cp=%b expected %b", nv, e,
                             {q, rp, fp, cp}, {eq, er, ef, er | ef});
                end
            end
        end
    endtask

    task automatic test_glitch();
        din = 1'b1;
        repeat (3) tick();
        din = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            total++;
            if ({q, rp, fp, cp} !== 4'b0000) begin
                bad++; $display("FAIL glitch3 edge %0d: q/rp/fp/cp=%b expected 0000", e, {q, rp, fp, cp});
            end
        end
        total++;
        if (dut.cnt_q !== 3'd0) begin
            bad++; $display("FAIL glitch_cnt: cnt=%0d expected 0", dut.cnt_q);
        end
        din = 1'b1;
        tick();
        din = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if ({q, rp, fp, cp} !== 4'b0000) begin
                bad++; $display("FAIL glitch1 edge %0d: q/rp/fp/cp=%b expected 0000", e, {q, rp, fp, cp});
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            din = pat[i];
            repeat (2) begin
                tick();
                total++;
                if ({q, rp, fp, cp} !== 4'b0000) begin
                    bad++; $display("FAIL bounce_pre step %0d: q/rp/fp/cp=%b expected 0000", i, {q, rp, fp, cp});
                end
            end
        end
        din = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            total++;
            if ({q, rp, fp, cp} !== {(e >= 7), (e == 7), 1'b0, (e == 7)}) begin
                bad++;
                $display("FAIL bounce edge %0d: q/rp/fp/cp=%b expected %b", e,
                         {q, rp, fp, cp}, {(e >= 7), (e == 7), 1'b0, (e == 7)});
            end
        end
    endtask

    task automatic test_gated();
        din = 1'b0;
        repeat (9) tick();
        total++;
        if (q !== 1'b0) begin
            bad++; $display("FAIL gated_setup: q=%b expected 0", q);
        end
        // Settle entered at edge 3; enabled edges 6, 9, 12, 15 -> commit at 15.
        din = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            sample_en = ((k % 3) == 0);
            tick();
            total++;
            if ({q, rp, fp, cp} !== {(k >= 15), (k == 15), 1'b0, (k == 15)}) begin
                bad++;
                $display("FAIL gated edge %0d: q/rp/fp/cp=%b expected %b", k,
                         {q, rp, fp, cp}, {(k >= 15), (k == 15), 1'b0, (k == 15)});
            end
        end
        sample_en = 1'b1;
    endtask

    task automatic test_reset_mid_settle();
        din = 1'b0;
        repeat (5) tick();
        total++;
        if (dut.cnt_q !== 3'd2 || q !== 1'b1) begin
            bad++; $display("FAIL mid_settle_pre: cnt=%0d q=%b expected cnt=2 q=1", dut.cnt_q, q);
        end
        #2; rst = 1'b1; #1;
        total++;
        if (dut.cnt_q !== 3'd0 || {q, rp, fp, cp} !== 4'b0000) begin
            bad++; $display("FAIL mid_settle_rst: cnt=%0d q/rp/fp/cp=%b expected 0 0000", dut.cnt_q, {q, rp, fp, cp});
        end
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            total++;
            if ({q, rp, fp, cp} !== 4'b0000) begin
                bad++; $display("FAIL mid_settle_after edge %0d: q/rp/fp/cp=%b expected 0000", e, {q, rp, fp, cp});
            end
        end
    endtask

    task automatic test_min_param();
        logic [1:0] seq;
        seq = 2'b01;
        for (int s = 0; s < 2; s++) begin
            logic nv;
            nv   = seq[s];
            din1 = nv;
            for (int e = 1; e <= 6; e++) begin
                logic eq;
                logic er;
                logic ef;
                tick();
                eq = (e >= 4) ? nv : ~nv;
                er = (e == 4) && nv;
                ef = (e == 4) && !nv;
                total++;
                if ({q1, rp1, fp1, cp1} !== {eq, er, ef, er | ef}) begin
                    bad++;
                    $display("FAIL min_param to %b edge %0d: q/rp/fp/cp=%b expected %b", nv, e,
                             {q1, rp1, fp1, cp1}, {eq, er, ef, er | ef});
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_gated();
        test_reset_mid_settle();
        test_min_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
